// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, forward codes,
// load-use FSM states and the shadow stage record.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [2:0] {
    FWD_RDAT    = 3'b000,
    FWD_EXM_ALU = 3'b001,
    FWD_MWB_ALU = 3'b010,
    FWD_EXM_UP  = 3'b011,
    FWD_MWB_UP  = 3'b100
  } fwd_t;

  typedef enum logic {
    RUN    = 1'b0,
    LSTALL = 1'b1
  } hz_state_t;

  typedef struct packed {
    regbits_t rs;
    regbits_t rt;
    logic     use_rs;
    logic     use_rt;
    regbits_t wsel;
    logic     wen;
    logic     load;
    logic     lui;
  } shadow_rec_t;

  localparam shadow_rec_t SHADOW_BUBBLE = '0;

  // r0 is hardwired, so a write to it never produces a value
  function automatic logic writes_reg(
    input shadow_rec_t p,
    input regbits_t    r
  );
    return p.wen && (p.wsel != '0) && (p.wsel == r);
  endfunction

  // a load ahead of the consumer whose data is not yet usable
  function automatic logic load_hit(
    input shadow_rec_t p,
    input regbits_t    r,
    input logic        use_r
  );
    return use_r && p.load && writes_reg(p, r);
  endfunction

  // EX/MEM beats MEM/WB; a load in MEM/WB goes through the
  // register file's write-before-read instead of a bypass
  function automatic fwd_t fwd_pick(
    input regbits_t    src,
    input logic        use_src,
    input shadow_rec_t m,
    input shadow_rec_t w
  );
    fwd_t sel;
    sel = FWD_RDAT;
    if (use_src && writes_reg(m, src))
      sel = m.lui ? FWD_EXM_UP : FWD_EXM_ALU;
    else if (use_src && writes_reg(w, src) && !w.load)
      sel = w.lui ? FWD_MWB_UP : FWD_MWB_ALU;
    return sel;
  endfunction

endpackage

// File: rtl/fwd_shadow_reg.sv
// One shadow stage register of register-usage metadata.
// hold beats bubble beats load.
module fwd_shadow_reg
  import cpu_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        bubble,
  input  shadow_rec_t d,
  output shadow_rec_t q
);

  // stage latch with synchronous clear
  always_ff @(posedge clk) begin
    if (rst)
      q <= SHADOW_BUBBLE;
    else if (!hold) begin
      if (bubble)
        q <= SHADOW_BUBBLE;
      else
        q <= d;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// ALU operand forward selects, load-use stall, memory
// freeze and stall-cycle counter from shadow stage state.
module fwd_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_wsel,
  input  logic             id_wen,
  input  logic             id_load,
  input  logic             id_lui,
  input  logic             flush,
  input  logic             dmem_req,
  input  logic             dhit,
  output logic [2:0]       forwarda,
  output logic [2:0]       forwardb,
  output logic             stall_id,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_count
);

  shadow_rec_t id_rec;
  shadow_rec_t s_ex;
  shadow_rec_t s_mem;
  shadow_rec_t s_wb;
  hz_state_t   state;
  hz_state_t   state_nx;
  logic        hazard;
  logic        ex_bubble;

  // ID record; an invalid slot enters as a bubble
  always_comb begin
    id_rec = SHADOW_BUBBLE;
    if (id_valid) begin
      id_rec.rs     = id_rs;
      id_rec.rt     = id_rt;
      id_rec.use_rs = id_use_rs;
      id_rec.use_rt = id_use_rt;
      id_rec.wsel   = id_wsel;
      id_rec.wen    = id_wen;
      id_rec.load   = id_load;
      id_rec.lui    = id_lui;
    end
  end

  // load in EX or MEM that the ID instruction reads
  always_comb begin
    hazard = id_valid && (
      load_hit(s_ex,  id_rs, id_use_rs) ||
      load_hit(s_ex,  id_rt, id_use_rt) ||
      load_hit(s_mem, id_rs, id_use_rs) ||
      load_hit(s_mem, id_rt, id_use_rt));
  end

  assign freeze    = dmem_req & ~dhit;
  assign stall_id  = hazard & ~flush;
  assign ex_bubble = stall_id | flush;

  fwd_shadow_reg u_ex (
    .clk    (CLK),
    .rst    (RST),
    .hold   (freeze),
    .bubble (ex_bubble),
    .d      (id_rec),
    .q      (s_ex)
  );

  fwd_shadow_reg u_mem (
    .clk    (CLK),
    .rst    (RST),
    .hold   (freeze),
    .bubble (1'b0),
    .d      (s_ex),
    .q      (s_mem)
  );

  fwd_shadow_reg u_wb (
    .clk    (CLK),
    .rst    (RST),
    .hold   (freeze),
    .bubble (1'b0),
    .d      (s_mem),
    .q      (s_wb)
  );

  // operand selects for the instruction now in EX
  always_comb begin
    forwarda = fwd_pick(s_ex.rs, s_ex.use_rs, s_mem, s_wb);
    forwardb = fwd_pick(s_ex.rt, s_ex.use_rt, s_mem, s_wb);
  end

  // load-use episode state register
  always_ff @(posedge CLK) begin
    if (RST)
      state <= RUN;
    else
      state <= state_nx;
  end

  // episode tracking; a memory wait freezes it too
  always_comb begin
    state_nx = state;
    unique case (state)
      RUN: begin
        if (!freeze && hazard && !flush)
          state_nx = LSTALL;
      end
      LSTALL: begin
        if (!freeze && (flush || !hazard))
          state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  // saturating count of stalled or frozen cycles
  always_ff @(posedge CLK) begin
    if (RST)
      stall_count <= '0;
    else if ((stall_id || freeze) &&
             (stall_count != {CNT_W{1'b1}}))
      stall_count <= stall_count + 1'b1;
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Vector-table bench for fwd_hazard_ctrl with an expected
// queue popped on the falling edge of each cycle.
module tb_fwd_hazard_ctrl;
  import cpu_types_pkg::*;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic          id_valid;
  logic [4:0]    id_rs;
  logic [4:0]    id_rt;
  logic          id_use_rs;
  logic          id_use_rt;
  logic [4:0]    id_wsel;
  logic          id_wen;
  logic          id_load;
  logic          id_lui;
  logic          flush;
  logic          dmem_req;
  logic          dhit;
  logic [2:0]    forwarda;
  logic [2:0]    forwardb;
  logic          stall_id;
  logic          freeze;
  logic [CW-1:0] stall_count;

  always #5 CLK = ~CLK;

  fwd_hazard_ctrl #(.CNT_W(CW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_wsel     (id_wsel),
    .id_wen      (id_wen),
    .id_load     (id_load),
    .id_lui      (id_lui),
    .flush       (flush),
    .dmem_req    (dmem_req),
    .dhit        (dhit),
    .forwarda    (forwarda),
    .forwardb    (forwardb),
    .stall_id    (stall_id),
    .freeze      (freeze),
    .stall_count (stall_count)
  );

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] wsel;
    logic       wen;
    logic       load;
    logic       lui;
  } id_t;

  typedef struct {
    id_t        id;
    logic       fl;
    logic       dq;
    logic       dh;
    logic       rs;
    logic [2:0] fa;
    logic [2:0] fb;
    logic       st;
    logic       fz;
    int         cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   ecnt   = 0;

  function automatic id_t i_nop();
    return '0;
  endfunction

  function automatic id_t i_alu(
    input logic [4:0] d,
    input logic [4:0] s,
    input logic [4:0] t
  );
    id_t r;
    r = '0;
    r.valid = 1'b1;
    r.rs = s;
    r.rt = t;
    r.urs = 1'b1;
    r.urt = 1'b1;
    r.wsel = d;
    r.wen = 1'b1;
    return r;
  endfunction

  function automatic id_t i_addi(
    input logic [4:0] d,
    input logic [4:0] s
  );
    id_t r;
    r = '0;
    r.valid = 1'b1;
    r.rs = s;
    r.urs = 1'b1;
    r.wsel = d;
    r.wen = 1'b1;
    return r;
  endfunction

  function automatic id_t i_lw(
    input logic [4:0] d,
    input logic [4:0] s
  );
    id_t r;
    r = i_addi(d, s);
    r.load = 1'b1;
    return r;
  endfunction

  function automatic id_t i_lui(input logic [4:0] d);
    id_t r;
    r = '0;
    r.valid = 1'b1;
    r.wsel = d;
    r.wen = 1'b1;
    r.lui = 1'b1;
    return r;
  endfunction

  // counter expectation: one per stalled/frozen cycle
  task automatic add(
    input id_t        id,
    input logic       fl,
    input logic       dq,
    input logic       dh,
    input logic       rs,
    input logic [2:0] fa,
    input logic [2:0] fb,
    input logic       st,
    input logic       fz
  );
    vec_t v;
    v.id = id;
    v.fl = fl;
    v.dq = dq;
    v.dh = dh;
    v.rs = rs;
    v.fa = fa;
    v.fb = fb;
    v.st = st;
    v.fz = fz;
    v.cnt = ecnt;
    if (rs)
      ecnt = 0;
    else if ((st || fz) && ecnt < CMAX)
      ecnt++;
    tbl.push_back(v);
  endtask

  task automatic a(
    input id_t        id,
    input logic [2:0] fa,
    input logic [2:0] fb,
    input logic       st
  );
    add(id, 1'b0, 1'b0, 1'b0, 1'b0, fa, fb, st, 1'b0);
  endtask

  task automatic chk(
    input string       nm,
    input int          idx,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0d want %0d",
               nm, idx, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    RST       = v.rs;
    id_valid  = v.id.valid;
    id_rs     = v.id.rs;
    id_rt     = v.id.rt;
    id_use_rs = v.id.urs;
    id_use_rt = v.id.urt;
    id_wsel   = v.id.wsel;
    id_wen    = v.id.wen;
    id_load   = v.id.load;
    id_lui    = v.id.lui;
    flush     = v.fl;
    dmem_req  = v.dq;
    dhit      = v.dh;
    sbq.push_back(v);
  endtask

  task automatic compare(input int idx);
    vec_t v;
    if (sbq.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sbq vec %0d: got empty want entry", idx);
    end else begin
      v = sbq.pop_front();
      chk("fwda",  idx, 32'(forwarda),    32'(v.fa));
      chk("fwdb",  idx, 32'(forwardb),    32'(v.fb));
      chk("stall", idx, 32'(stall_id),    32'(v.st));
      chk("frz",   idx, 32'(freeze),      32'(v.fz));
      chk("cnt",   idx, 32'(stall_count), 32'(v.cnt));
    end
  endtask

  initial begin
    // back-to-back ALU, EX/MEM forward on A
    a(i_alu(3, 1, 2), 0, 0, 0);
    a(i_alu(4, 3, 5), 0, 0, 0);
    a(i_nop(), 1, 0, 0);
    a(i_nop(), 0, 0, 0);
    a(i_nop(), 0, 0, 0);
    // LUI, NOP, consumer: upper16 from MEM/WB
    a(i_lui(7), 0, 0, 0);
    a(i_nop(), 0, 0, 0);
    a(i_alu(8, 0, 7), 0, 0, 0);
    a(i_nop(), 0, 4, 0);
    // LUI then consumer: upper16 from EX/MEM
    a(i_lui(7), 0, 0, 0);
    a(i_alu(8, 0, 7), 0, 0, 0);
    a(i_nop(), 0, 3, 0);
    a(i_nop(), 0, 0, 0);
    a(i_nop(), 0, 0, 0);
    // load directly ahead: two stall cycles
    a(i_lw(2, 1), 0, 0, 0);
    a(i_alu(6, 2, 2), 0, 0, 1);
    a(i_alu(6, 2, 2), 0, 0, 1);
    a(i_alu(6, 2, 2), 0, 0, 0);
    a(i_nop(), 0, 0, 0);
    a(i_nop(), 0, 0, 0);
    a(i_nop(), 0, 0, 0);
    // load two ahead: one stall cycle
    a(i_lw(2, 1), 0, 0, 0);
    a(i_nop(), 0, 0, 0);
    a(i_alu(6, 2, 2), 0, 0, 1);
    a(i_alu(6, 2, 2), 0, 0, 0);
    a(i_nop(), 0, 0, 0);
    a(i_nop(), 0, 0, 0);
    a(i_nop(), 0, 0, 0);
    // r0 never forwarded
    a(i_addi(0, 1), 0, 0, 0);
    a(i_alu(10, 0, 0), 0, 0, 0);
    a(i_nop(), 0, 0, 0);
    // r9 in both stages: EX/MEM ALU wins over WB LUI
    a(i_lui(9), 0, 0, 0);
    a(i_addi(9, 1), 0, 0, 0);
    a(i_alu(11, 9, 9), 0, 0, 0);
    a(i_nop(), 1, 1, 0);
    // plain MEM/WB ALU forward on A
    a(i_alu(12, 1, 1), 0, 0, 0);
    a(i_nop(), 0, 0, 0);
    a(i_alu(13, 12, 0), 0, 0, 0);
    a(i_nop(), 2, 0, 0);
    a(i_nop(), 0, 0, 0);
    a(i_nop(), 0, 0, 0);
    // memory wait during a load-use stall
    a(i_alu(1, 3, 4), 0, 0, 0);
    a(i_lw(2, 1), 0, 0, 0);
    for (int k = 0; k < 3; k++)
      add(i_alu(6, 2, 2), 0, 1, 0, 0, 1, 0, 1, 1);
    add(i_alu(6, 2, 2), 0, 1, 1, 0, 1, 0, 1, 0);
    a(i_alu(6, 2, 2), 0, 0, 1);
    a(i_alu(6, 2, 2), 0, 0, 0);
    a(i_nop(), 0, 0, 0);
    a(i_nop(), 0, 0, 0);
    a(i_nop(), 0, 0, 0);
    // flush with a hazard: no stall, bubble into EX
    a(i_lw(2, 1), 0, 0, 0);
    add(i_alu(6, 2, 2), 1, 0, 0, 0, 0, 0, 0, 0);
    a(i_nop(), 0, 0, 0);
    a(i_nop(), 0, 0, 0);
    // reset in the middle of a stall episode
    a(i_lw(2, 1), 0, 0, 0);
    a(i_alu(6, 2, 2), 0, 0, 1);
    add(i_alu(6, 2, 2), 0, 0, 0, 1, 0, 0, 1, 0);
    a(i_alu(6, 2, 2), 0, 0, 0);
    a(i_nop(), 0, 0, 0);
    a(i_nop(), 0, 0, 0);
    a(i_nop(), 0, 0, 0);
    // long memory wait drives the counter to saturation
    for (int k = 0; k < CMAX + 5; k++)
      add(i_nop(), 0, 1, 0, 0, 0, 0, 0, 1);
    a(i_nop(), 0, 0, 0);
    add(i_nop(), 0, 0, 0, 1, 0, 0, 0, 0);
    a(i_nop(), 0, 0, 0);

    RST = 1'b1;
    drive('{default: '0});
    RST = 1'b1;
    void'(sbq.pop_front());
    @(posedge CLK);
    @(posedge CLK);
    for (int i = 0; i < tbl.size(); i++) begin
      #1;
      drive(tbl[i]);
      @(negedge CLK);
      compare(i);
      @(posedge CLK);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Controller for the ALU operand forwarding muxes (A and B) in the 5-stage pipeline.
- Keeps its own shadow copy of the register-usage metadata for the ID/EX, EX/MEM and MEM/WB stages, and advances that copy in lockstep with the datapath latches.
- From the shadow copy it produces the 3-bit forward selects, the load-use stall, pipeline freeze on data-memory wait, and a stall-cycle counter.
- Sits beside the hazard/forward logic in the datapath top level.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous reset, active-high.
- id_valid  in  1  the ID stage holds a real instruction (0 means bubble).
- id_rs  in  5  ID source register rs.
- id_rt  in  5  ID source register rt.
- id_use_rs  in  1  the ID instruction reads rs.
- id_use_rt  in  1  the ID instruction reads rt.
- id_wsel  in  5  ID destination register.
- id_wen  in  1  the ID instruction writes the register file.
- id_load  in  1  the ID instruction is a load.
- id_lui  in  1  the ID instruction is LUI; its result appears on the upper16 path.
- flush  in  1  branch/jump taken; the ID instruction is squashed into ID/EX.
- dmem_req  in  1  the MEM stage has a data read or write outstanding.
- dhit  in  1  the data memory access completes this cycle.
- forwarda  out  3  ALU A select.
- forwardb  out  3  ALU B select.
- stall_id  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- freeze  out  1  hold every pipeline latch.
- stall_count  out  CNT_W  cycles in which stall_id or freeze was high; saturates.

Behaviour:
Forward codes (fwd_t):
- FWD_RDAT = 000: register-file read data.
- FWD_EXM_ALU = 001: ALU result from EX/MEM.
- FWD_MWB_ALU = 010: ALU result from MEM/WB.
- FWD_EXM_UP = 011: upper16 from EX/MEM.
- FWD_MWB_UP = 100: upper16 from MEM/WB.
- Codes 101–111 are never driven.

Shadow stage record (fields: rs, rt, use_rs, use_rt, wsel, wen, load, lui):
- Three registers: S_EX, S_MEM, S_WB.
- On reset all fields are 0, so wen=0 everywhere.

Advance, evaluated on every clock:
- freeze=1: all shadow registers hold.
- Else if stall_id=1 or flush=1: S_EX takes a bubble (all zero), S_MEM takes S_EX, S_WB takes S_MEM.
- Else: S_EX takes the ID record (a bubble if id_valid=0), S_MEM takes S_EX, S_WB takes S_MEM.

Forward select (combinational from shadow state; forwardb is identical with rt in place of rs):
- A producer "matches" when: wen=1, wsel≠0, wsel equals S_EX.rs, and S_EX.use_rs=1.
- If S_MEM matches: select FWD_EXM_UP when S_MEM.lui=1, else FWD_EXM_ALU.
- Else if S_WB matches and S_WB.load=0: select FWD_MWB_UP when S_WB.lui=1, else FWD_MWB_ALU.
- Otherwise: FWD_RDAT.
- There is no load-data forward path. Correctness relies on the load-use stall below plus the register file's write-before-read in WB.

Load-use stall:
- Hazard condition: the ID instruction is valid and uses a nonzero source register that equals S_EX.wsel (with S_EX.load and wen set) or S_MEM.wsel (with S_MEM.load and wen set).
- FSM states:
  - RUN: on the hazard with freeze=0, go to LSTALL, stall_id=1.
  - LSTALL: stall_id=1 while the hazard persists (2 cycles for a load directly ahead of the consumer, 1 for a load two ahead); return to RUN when it clears.
- stall_id is the combinational hazard term. The FSM state only records the stall episode, for the counter and the freeze interaction.
- flush=1 in the same cycle as the hazard: flush wins, stall_id=0, and the FSM goes to RUN.

Memory wait:
- freeze = dmem_req & ~dhit, independent of FSM state.
- While freeze=1, the FSM holds its state.
- stall_id stays at its combinational value, but the shadow registers do not advance.

Counter:
- stall_count increments by 1 in each cycle where stall_id or freeze is 1.
- It holds at 2^CNT_W−1.

Reset:
- Clears all shadow registers, the FSM (to RUN) and stall_count.
- Outputs after reset: forwarda=forwardb=000, stall_id=0; freeze follows its inputs.
- A reset asserted mid-stall drops the stall on the next edge.

Decomposition:
- Add to cpu_types_pkg: fwd_t enum (the 3-bit codes above), hz_state_t enum {RUN, LSTALL}, and the shadow_rec_t packed struct. regbits_t is already present there.
- Sub-module: fwd_shadow_reg, one shadow stage register with hold/bubble/load controls, instantiated three times.

Test Plan:
- ADD r3 then SUB r4,r3,r5 back-to-back → in SUB's EX cycle, forwarda=001, forwardb=000, stall_id=0.
- LUI r7 then OR r8,r0,r7 with one NOP between → forwardb=100; with no NOP → forwardb=011.
- LW r2 then ADD r6,r2,r2 → stall_id=1 for exactly 2 cycles, then forwarda=forwardb=000; stall_count=2.
- ADDI r0 then ADD using r0 → forwarda=000 (r0 never forwarded); r9 written by both EX/MEM and MEM/WB → 001 (EX/MEM has priority).
- dmem_req=1, dhit=0 for 3 cycles during a load-use stall → freeze=1 for 3 cycles, selects frozen, stall_count increments every cycle; stall_count at max stays max.
- Hazard with flush=1 on the same cycle → stall_id=0 and a bubble enters S_EX; RST pulsed in LSTALL → next cycle RUN, outputs 000/0, stall_count=0.
